// File: rtl/ldpc_iter_sched.sv
// ldpc_iter_sched
// ---------------------------------------------------------------------------
// Iteration scheduler for the layered-flooding LDPC decoder core. It steps the
// shared VNU array and CNU array through alternating variable-node and
// check-node phases, issuing one column/row group per cycle. It produces the
// message-RAM read/write addresses and the pipeline enables for each phase.
// It ANDs together the per-group parity results. Decoding stops on a zero
// syndrome, or after MAX_ITER iterations.
//
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   start         : begin a new frame (only looked at in IDLE)
//   vnu_en        : VNU array enable (issue + drain cycles)
//   vnu_rd_addr   : VNU group read address
//   vnu_first     : first VNU phase of the frame (X inputs forced to 0)
//   vnu_wr_valid  : VNU result valid for vnu_wr_addr
//   vnu_wr_addr   : VNU write-back address (issue address delayed VNU_LAT)
//   cnu_en        : CNU array enable (issue + drain cycles)
//   cnu_rd_addr   : CNU group read address
//   cnu_wr_valid  : CNU result valid for cnu_wr_addr
//   cnu_wr_addr   : CNU write-back address (issue address delayed CNU_LAT)
//   parity_ok     : group parity from the CNU, qualified by cnu_wr_valid
//   busy          : frame in progress
//   done          : one-cycle end-of-frame pulse
//   success       : zero syndrome reached (valid with done, held)
//   iter_count    : completed iterations (held after done)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ldpc_iter_sched #(
  parameter int G_V      = 4,
  parameter int G_C      = 3,
  parameter int VNU_LAT  = 2,
  parameter int CNU_LAT  = 1,
  parameter int MAX_ITER = 8,
  parameter int AW       = 4,
  parameter int IW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          vnu_en,
  output logic [AW-1:0] vnu_rd_addr,
  output logic          vnu_first,
  output logic          vnu_wr_valid,
  output logic [AW-1:0] vnu_wr_addr,
  output logic          cnu_en,
  output logic [AW-1:0] cnu_rd_addr,
  output logic          cnu_wr_valid,
  output logic [AW-1:0] cnu_wr_addr,
  input  logic          parity_ok,
  output logic          busy,
  output logic          done,
  output logic          success,
  output logic [IW-1:0] iter_count
);

  // The drain counter only has to cover the longer of the two pipelines.
  localparam int LMAX = (VNU_LAT > CNU_LAT) ? VNU_LAT : CNU_LAT;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_V_ISSUE = 3'd1,
    S_V_DRAIN = 3'd2,
    S_C_ISSUE = 3'd3,
    S_C_DRAIN = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] vaddr_q, vaddr_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic          first_q, first_d;
  logic          acc_q, acc_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          success_q, success_d;

  logic          v_issue, c_issue;
  logic          acc_now;
  logic [IW-1:0] iter_inc;

  // Write-back delay lines: stage 0 is fed by the issue strobe/address, and
  // the last stage drives the write-back outputs.
  logic [VNU_LAT-1:0] vv_q;
  logic [AW-1:0]      va_q [VNU_LAT];
  logic [CNU_LAT-1:0] cv_q;
  logic [AW-1:0]      ca_q [CNU_LAT];

  assign v_issue = (state_q == S_V_ISSUE);
  assign c_issue = (state_q == S_C_ISSUE);

  genvar gi;
  generate
    for (gi = 0; gi < VNU_LAT; gi++) begin : g_vdly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            vv_q[gi] <= 1'b0;
            va_q[gi] <= '0;
          end else begin
            vv_q[gi] <= v_issue;
            va_q[gi] <= vaddr_q;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            vv_q[gi] <= 1'b0;
            va_q[gi] <= '0;
          end else begin
            vv_q[gi] <= vv_q[gi-1];
            va_q[gi] <= va_q[gi-1];
          end
        end
      end
    end

    for (gi = 0; gi < CNU_LAT; gi++) begin : g_cdly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            cv_q[gi] <= 1'b0;
            ca_q[gi] <= '0;
          end else begin
            cv_q[gi] <= c_issue;
            ca_q[gi] <= caddr_q;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            cv_q[gi] <= 1'b0;
            ca_q[gi] <= '0;
          end else begin
            cv_q[gi] <= cv_q[gi-1];
            ca_q[gi] <= ca_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign vnu_wr_valid = vv_q[VNU_LAT-1];
  assign vnu_wr_addr  = va_q[VNU_LAT-1];
  assign cnu_wr_valid = cv_q[CNU_LAT-1];
  assign cnu_wr_addr  = ca_q[CNU_LAT-1];

  assign vnu_en      = v_issue | (state_q == S_V_DRAIN);
  assign vnu_rd_addr = vaddr_q;
  assign vnu_first   = v_issue & first_q;
  assign cnu_en      = c_issue | (state_q == S_C_DRAIN);
  assign cnu_rd_addr = caddr_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done        = (state_q == S_FIN);
  assign success     = success_q;
  assign iter_count  = iter_q;

  // The accumulator already includes the current cycle's parity result. This
  // lets the final C_DRAIN decision see the last group's outcome.
  assign acc_now  = acc_q & (~cnu_wr_valid | parity_ok);
  assign iter_inc = iter_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vaddr_d   = vaddr_q;
    caddr_d   = caddr_q;
    first_d   = first_q;
    acc_d     = acc_now;
    iter_d    = iter_q;
    success_d = success_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_V_ISSUE;
          vaddr_d   = '0;
          iter_d    = '0;
          success_d = 1'b0;
          first_d   = 1'b1;
        end
      end
      S_V_ISSUE: begin
        if (vaddr_q == AW'(G_V - 1)) begin
          state_d = S_V_DRAIN;
          cnt_d   = '0;
        end else begin
          vaddr_d = vaddr_q + AW'(1);
        end
      end
      S_V_DRAIN: begin
        if (cnt_q == CW'(VNU_LAT - 1)) begin
          state_d = S_C_ISSUE;
          caddr_d = '0;
          first_d = 1'b0;
          acc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_C_ISSUE: begin
        if (caddr_q == AW'(G_C - 1)) begin
          state_d = S_C_DRAIN;
          cnt_d   = '0;
        end else begin
          caddr_d = caddr_q + AW'(1);
        end
      end
      S_C_DRAIN: begin
        if (cnt_q == CW'(CNU_LAT - 1)) begin
          iter_d = iter_inc;
          if (acc_now) begin
            success_d = 1'b1;
            state_d   = S_FIN;
          end else if (iter_inc == IW'(MAX_ITER)) begin
            success_d = 1'b0;
            state_d   = S_FIN;
          end else begin
            state_d = S_V_ISSUE;
            vaddr_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vaddr_q   <= '0;
      caddr_q   <= '0;
      first_q   <= 1'b0;
      acc_q     <= 1'b0;
      iter_q    <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vaddr_q   <= vaddr_d;
      caddr_q   <= caddr_d;
      first_q   <= first_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      success_q <= success_d;
    end
  end

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// tb_ldpc_iter_sched
// Drives two scheduler instances from shared random start/reset stimulus:
// the default configuration and the minimal G=1/LAT=1/MAX_ITER=1 one. Each
// instance has its own random parity_ok stream. Every cycle the outputs are
// compared with a frame-level model. The model places each cycle inside an
// iteration by its offset from the accepted start.
`timescale 1ns/1ps
module tb_ldpc_iter_sched;

  localparam int NCYC = 6000;

  typedef struct {
    int gv; int gc; int vl; int cl; int mi;
  } cfg_t;

  typedef struct {
    bit busy; bit fin; bit clean; int off; bit fail; int iter; bit success;
  } ms_t;

  typedef struct {
    int vnu_en; int vfirst; int vrd_chk; int vrd; int vwv; int vwa;
    int cnu_en; int crd_chk; int crd; int cwv; int cwa;
    int busy; int done; int success; int iter; int clean;
  } exp_t;

  typedef struct {
    logic [31:0] vnu_en, vrd, vfirst, vwv, vwa, cnu_en, crd, cwv, cwa;
    logic [31:0] busy, done, success, iter;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pok_a, pok_b;

  logic       a_vnu_en, a_vnu_first, a_vnu_wr_valid, a_cnu_en, a_cnu_wr_valid;
  logic       a_busy, a_done, a_success;
  logic [3:0] a_vnu_rd_addr, a_vnu_wr_addr, a_cnu_rd_addr, a_cnu_wr_addr, a_iter;

  logic       b_vnu_en, b_vnu_first, b_vnu_wr_valid, b_cnu_en, b_cnu_wr_valid;
  logic       b_busy, b_done, b_success;
  logic [1:0] b_vnu_rd_addr, b_vnu_wr_addr, b_cnu_rd_addr, b_cnu_wr_addr, b_iter;

  ldpc_iter_sched dut_a (
    .clk(clk), .rst(rst), .start(start),
    .vnu_en(a_vnu_en), .vnu_rd_addr(a_vnu_rd_addr), .vnu_first(a_vnu_first),
    .vnu_wr_valid(a_vnu_wr_valid), .vnu_wr_addr(a_vnu_wr_addr),
    .cnu_en(a_cnu_en), .cnu_rd_addr(a_cnu_rd_addr),
    .cnu_wr_valid(a_cnu_wr_valid), .cnu_wr_addr(a_cnu_wr_addr),
    .parity_ok(pok_a), .busy(a_busy), .done(a_done),
    .success(a_success), .iter_count(a_iter)
  );

  ldpc_iter_sched #(
    .G_V(1), .G_C(1), .VNU_LAT(1), .CNU_LAT(1), .MAX_ITER(1), .AW(2), .IW(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .vnu_en(b_vnu_en), .vnu_rd_addr(b_vnu_rd_addr), .vnu_first(b_vnu_first),
    .vnu_wr_valid(b_vnu_wr_valid), .vnu_wr_addr(b_vnu_wr_addr),
    .cnu_en(b_cnu_en), .cnu_rd_addr(b_cnu_rd_addr),
    .cnu_wr_valid(b_cnu_wr_valid), .cnu_wr_addr(b_cnu_wr_addr),
    .parity_ok(pok_b), .busy(b_busy), .done(b_done),
    .success(b_success), .iter_count(b_iter)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ms_t model_reset();
    ms_t s;
    s.busy = 0; s.fin = 0; s.clean = 1; s.off = 0; s.fail = 0; s.iter = 0; s.success = 0;
    return s;
  endfunction

  // Expected outputs for the current cycle, derived from the cycle offset
  // within the frame and the iteration length.
  function automatic exp_t model_out(cfg_t c, ms_t s);
    exp_t e;
    int len, p, cst;
    len = c.gv + c.vl + c.gc + c.cl;
    p   = s.off % len;
    cst = c.gv + c.vl;
    e.vnu_en  = int'(s.busy && p < cst);
    e.vrd_chk = int'(s.busy && p < c.gv);
    e.vrd     = p;
    e.vfirst  = int'(s.busy && s.off < c.gv);
    e.vwv     = int'(s.busy && p >= c.vl && p < c.vl + c.gv);
    e.vwa     = p - c.vl;
    e.cnu_en  = int'(s.busy && p >= cst);
    e.crd_chk = int'(s.busy && p >= cst && p < cst + c.gc);
    e.crd     = p - cst;
    e.cwv     = int'(s.busy && p >= cst + c.cl);
    e.cwa     = p - cst - c.cl;
    e.busy    = int'(s.busy);
    e.done    = int'(s.fin);
    e.success = int'(s.success);
    e.iter    = s.iter;
    e.clean   = int'(s.clean);
    return e;
  endfunction

  function automatic ms_t model_next(cfg_t c, ms_t s, bit r, bit st, bit pok);
    ms_t n;
    int len, p;
    n   = s;
    len = c.gv + c.vl + c.gc + c.cl;
    p   = s.off % len;
    if (r) begin
      n = model_reset();
    end else if (s.fin) begin
      n.fin = 0;
    end else if (s.busy) begin
      if (p >= c.gv + c.vl + c.cl && !pok) n.fail = 1;
      if (p == len - 1) begin
        n.iter = s.iter + 1;
        if (!n.fail) begin
          n.success = 1; n.busy = 0; n.fin = 1;
        end else if (n.iter == c.mi) begin
          n.success = 0; n.busy = 0; n.fin = 1;
        end else begin
          n.fail = 0;
        end
      end
      n.off = s.off + 1;
    end else if (st) begin
      n.busy = 1; n.clean = 0; n.off = 0; n.iter = 0; n.success = 0; n.fail = 0;
    end
    return n;
  endfunction

  task automatic check_dut(input string who, input exp_t e, input obs_t o);
    check_eq({who, ".vnu_en"},       o.vnu_en,  32'(e.vnu_en));
    check_eq({who, ".vnu_first"},    o.vfirst,  32'(e.vfirst));
    check_eq({who, ".vnu_wr_valid"}, o.vwv,     32'(e.vwv));
    check_eq({who, ".cnu_en"},       o.cnu_en,  32'(e.cnu_en));
    check_eq({who, ".cnu_wr_valid"}, o.cwv,     32'(e.cwv));
    check_eq({who, ".busy"},         o.busy,    32'(e.busy));
    check_eq({who, ".done"},         o.done,    32'(e.done));
    check_eq({who, ".success"},      o.success, 32'(e.success));
    check_eq({who, ".iter_count"},   o.iter,    32'(e.iter));
    if (e.vrd_chk != 0) check_eq({who, ".vnu_rd_addr"}, o.vrd, 32'(e.vrd));
    if (e.crd_chk != 0) check_eq({who, ".cnu_rd_addr"}, o.crd, 32'(e.crd));
    if (e.vwv != 0)     check_eq({who, ".vnu_wr_addr"}, o.vwa, 32'(e.vwa));
    if (e.cwv != 0)     check_eq({who, ".cnu_wr_addr"}, o.cwa, 32'(e.cwa));
    if (e.clean != 0) begin
      check_eq({who, ".rst_vnu_rd_addr"}, o.vrd, 32'd0);
      check_eq({who, ".rst_cnu_rd_addr"}, o.crd, 32'd0);
      check_eq({who, ".rst_vnu_wr_addr"}, o.vwa, 32'd0);
      check_eq({who, ".rst_cnu_wr_addr"}, o.cwa, 32'd0);
    end
  endtask

  function automatic int pick_thr();
    int tbl [5] = '{100, 96, 85, 50, 0};
    return tbl[$urandom_range(0, 4)];
  endfunction

  initial begin
    cfg_t ca, cb;
    ms_t  sa, sb;
    exp_t ea, eb;
    obs_t oa, ob;
    int   thr_a, thr_b;

    ca = '{gv: 4, gc: 3, vl: 2, cl: 1, mi: 8};
    cb = '{gv: 1, gc: 1, vl: 1, cl: 1, mi: 1};
    sa = model_reset();
    sb = model_reset();
    thr_a = 100; thr_b = 0;
    rst = 1'b1; start = 1'b0; pok_a = 1'b1; pok_b = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      ea = model_out(ca, sa);
      eb = model_out(cb, sb);

      oa.vnu_en = 32'(a_vnu_en); oa.vrd = 32'(a_vnu_rd_addr); oa.vfirst = 32'(a_vnu_first);
      oa.vwv = 32'(a_vnu_wr_valid); oa.vwa = 32'(a_vnu_wr_addr); oa.cnu_en = 32'(a_cnu_en);
      oa.crd = 32'(a_cnu_rd_addr); oa.cwv = 32'(a_cnu_wr_valid); oa.cwa = 32'(a_cnu_wr_addr);
      oa.busy = 32'(a_busy); oa.done = 32'(a_done); oa.success = 32'(a_success);
      oa.iter = 32'(a_iter);

      ob.vnu_en = 32'(b_vnu_en); ob.vrd = 32'(b_vnu_rd_addr); ob.vfirst = 32'(b_vnu_first);
      ob.vwv = 32'(b_vnu_wr_valid); ob.vwa = 32'(b_vnu_wr_addr); ob.cnu_en = 32'(b_cnu_en);
      ob.crd = 32'(b_cnu_rd_addr); ob.cwv = 32'(b_cnu_wr_valid); ob.cwa = 32'(b_cnu_wr_addr);
      ob.busy = 32'(b_busy); ob.done = 32'(b_done); ob.success = 32'(b_success);
      ob.iter = 32'(b_iter);

      check_dut("A", ea, oa);
      check_dut("B", eb, ob);

      if (ea.done != 0)
        $display("frame A cycle %0d: done success=%0d iter_count=%0d (thr=%0d)",
                 cyc, a_success, a_iter, thr_a);
      if (eb.done != 0)
        $display("frame B cycle %0d: done success=%0d iter_count=%0d", cyc, b_success, b_iter);

      // Inputs for the edge that ends this cycle.
      rst   = (cyc < 3) || ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 7) == 0);
      if (!rst && start && !sa.busy && !sa.fin) thr_a = pick_thr();
      if (!rst && start && !sb.busy && !sb.fin) thr_b = pick_thr();
      pok_a = ($urandom_range(0, 99) < thr_a);
      pok_b = ($urandom_range(0, 99) < thr_b);

      sa = model_next(ca, sa, rst, start, pok_a);
      sb = model_next(cb, sb, rst, start, pok_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_sched.md
Name: ldpc_iter_sched

Overview:
- Iteration scheduler for the layered-flooding LDPC decoder core.
- Sequences the shared VNU array and CNU array through alternating variable-node and check-node phases, one column/row group per cycle.
- Generates message-RAM read/write addresses and pipeline enables for each phase.
- Accumulates per-group parity results and terminates early on a zero syndrome, or after MAX_ITER iterations.

Parameters:
- G_V, 4: number of VNU groups processed serially per VNU phase (>=1).
- G_C, 3: number of CNU groups processed serially per CNU phase (>=1).
- VNU_LAT, 2: VNU pipeline depth in cycles, from enabled input to registered Y/hard_decision.
- CNU_LAT, 1: CNU pipeline depth in cycles (>=1).
- MAX_ITER, 8: maximum number of decoding iterations (>=1).
- AW, 4: address width; must hold max(G_V, G_C)-1.
- IW, 4: iteration counter width; must hold MAX_ITER.

Ports:
- clk in 1: system clock; all logic on its rising edge.
- rst in 1: synchronous, active-high reset.
- start in 1: begin decoding a new frame; sampled only in IDLE.
- vnu_en out 1: enable for the VNU array's `en` port.
- vnu_rd_addr out AW: group address for intrinsic RAM and CNU→VNU message RAM reads.
- vnu_first out 1: high during the first VNU phase; VNU X inputs are forced to 0.
- vnu_wr_valid out 1: VNU output (Y, hard_decision) for vnu_wr_addr is valid this cycle.
- vnu_wr_addr out AW: write-back address for VNU output.
- cnu_en out 1: CNU array enable.
- cnu_rd_addr out AW: group address for VNU→CNU message RAM reads.
- cnu_wr_valid out 1: CNU output for cnu_wr_addr is valid this cycle.
- cnu_wr_addr out AW: write-back address for CNU output.
- parity_ok in 1: from CNU; 1 when every check in the group currently written is satisfied. Qualified by cnu_wr_valid.
- busy out 1: high from the cycle after start is accepted until done.
- done out 1: one-cycle pulse at the end of decoding.
- success out 1: valid with done, held until the next accepted start; 1 = zero syndrome.
- iter_count out IW: number of completed iterations; held after done.

Behaviour:
- **Reset values.** On rst all outputs are 0. State goes to IDLE and all counters, address delay lines and the parity accumulator clear. rst mid-frame aborts immediately, with no done pulse.
- **States.** IDLE, V_ISSUE, V_DRAIN, C_ISSUE, C_DRAIN, FIN.
- **IDLE.**
  - Entered on start=1: clear iter_count and success, set first flag, go to V_ISSUE next cycle.
  - start is ignored in every other state.
- **V_ISSUE (G_V cycles).**
  - vnu_en=1.
  - vnu_rd_addr = 0,1,…,G_V-1, one per cycle.
  - vnu_first = first flag.
- **V_DRAIN (VNU_LAT cycles).**
  - vnu_en stays 1 so the VNU pipeline advances.
  - vnu_rd_addr holds its last value; its content is don't-care.
- **VNU write-back timing.**
  - vnu_wr_valid/vnu_wr_addr are the issue-valid/address delayed exactly VNU_LAT cycles through a shift register.
  - Address k issued in cycle t appears at write-back in cycle t+VNU_LAT.
  - The last write-back therefore coincides with the final V_DRAIN cycle.
- **C_ISSUE and C_DRAIN.**
  - Same pattern as the VNU phase, using cnu_en, cnu_rd_addr, G_C, CNU_LAT and cnu_wr_*.
  - first flag clears on entry to C_ISSUE.
- **Parity accumulator.**
  - Set to 1 on entry to C_ISSUE.
  - ANDed with parity_ok on every cycle where cnu_wr_valid=1.
- **End of C_DRAIN (last cycle, including that cycle's parity_ok).**
  - iter_count increments.
  - If the accumulator is 1: success=1, go to FIN.
  - Else if the incremented iter_count == MAX_ITER: success=0, go to FIN.
  - Else go to V_ISSUE.
- **FIN.** done=1 for one cycle, busy drops in the same cycle, then return to IDLE. A start arriving in the FIN cycle is ignored.
- **Iteration length.** G_V+VNU_LAT+G_C+CNU_LAT cycles. The first V_ISSUE cycle is the cycle after start is sampled.
- **Enable exclusivity.** vnu_en and cnu_en are never 1 in the same cycle, and both are 0 in IDLE and FIN.
- **parity_ok.** Ignored when cnu_wr_valid=0.
- **G=1 case.** The ISSUE state lasts exactly one cycle, and address 0 is issued.

Test Plan:
- **Early termination, iteration 1.** Defaults; start pulse at cycle 0; parity_ok=1 always.
  - vnu_en high cycles 1–6; vnu_rd_addr 0,1,2,3 in cycles 1–4; vnu_wr_valid with addr 0..3 in cycles 3–6.
  - cnu_en high cycles 7–10; cnu_wr addr 0..2 in cycles 8–10.
  - done in cycle 11 with success=1, iter_count=1.
- **Max iterations.** parity_ok held 0.
  - Exactly 8 iterations of 10 cycles each.
  - done in cycle 81 with success=0, iter_count=8.
  - vnu_first high only in cycles 1–4.
- **Single failing group.** parity_ok=0 only on cnu_wr_addr=2 during iterations 1–2, 1 afterwards.
  - done after iteration 3, success=1, iter_count=3.
- **Start while busy.** start re-pulsed at cycles 5 and 40 during the max-iteration run.
  - Timing unchanged; still exactly one done pulse.
- **Reset mid-frame.** rst at cycle 15 for 1 cycle.
  - All outputs 0 from cycle 16; no done pulse.
  - A new start at cycle 20 behaves identically to scenario 1, shifted by 20 cycles.
- **Minimal configuration.** G_V=G_C=1, VNU_LAT=CNU_LAT=1, MAX_ITER=1, parity_ok=0.
  - vnu_en in cycles 1–2; cnu_en in cycles 3–4.
  - done in cycle 5 with success=0, iter_count=1.
